// File: rtl/gol_pkg.sv
// Shared definitions for the 4x4 toroidal Game-of-Life engine and its seeder.
package gol_pkg;

    localparam int GOL_CELLS = 16;
    localparam int GOL_CNT_W = 9;
    localparam int GOL_IDX_W = 4;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'b00,
        LD_SHIFT  = 2'b01,
        LD_SETTLE = 2'b10,
        LD_COMMIT = 2'b11
    } ldState_t;

    // Reference live-cell count of a 16-cell board; result range 0..16.
    function automatic logic [4:0] gol_popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/seed_popcount.sv
// 16-to-5 combinational adder tree: counts live cells of a board word.
module seed_popcount (
    input  logic [15:0] bits,
    output logic [4:0]  pop
);

    logic [7:0][1:0] lvl1;
    logic [3:0][2:0] lvl2;
    logic [1:0][3:0] lvl3;

    for (genvar i = 0; i < 8; i++) begin : gLvl1
        assign lvl1[i] = {1'b0, bits[2*i]} + {1'b0, bits[2*i+1]};
    end

    for (genvar i = 0; i < 4; i++) begin : gLvl2
        assign lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    end

    for (genvar i = 0; i < 2; i++) begin : gLvl3
        assign lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
    end

    assign pop = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};

endmodule

// File: rtl/seed_loader.sv
// Bit-serial board seeder: accepts a 16-cell seed, streams it one cell per
// cycle into the datapath's serial load port, then commits it with writeout.
module seed_loader
    import gol_pkg::*;
#(
    parameter int CELLS     = GOL_CELLS,
    parameter int CNT_W     = GOL_CNT_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             seed_valid,
    input  logic [CELLS-1:0] seed_data,
    output logic             seed_ready,
    input  logic             hold,
    output logic             DataIn,
    output logic [CNT_W-1:0] count,
    output logic             loadData,
    output logic             writeData,
    output logic             readData,
    output logic             writeout,
    output logic             busy,
    output logic             load_done,
    output logic [4:0]       seed_pop,
    output logic             empty_seed
);

    ldState_t             state, stateNext;
    logic [CELLS-1:0]     shiftReg;
    logic [CELLS-1:0]     seedOrdered;
    logic [GOL_IDX_W-1:0] idx;
    logic [4:0]           popNow;
    logic                 accept;
    logic                 lastCell;

    seed_popcount uPop (
        .bits (seed_data),
        .pop  (popNow)
    );

    assign lastCell   = (idx == GOL_IDX_W'(CELLS - 1));
    assign DataIn     = shiftReg[0];
    assign count      = {{(CNT_W - GOL_IDX_W){1'b0}}, idx};
    assign readData   = 1'b0;
    assign busy       = (state != LD_IDLE);

    // Put cell 0 at shiftReg[0] regardless of the seed's bit order.
    always_comb begin
        seedOrdered = seed_data;
        if (!LSB_FIRST)
            for (int k = 0; k < CELLS; k++) seedOrdered[k] = seed_data[CELLS-1-k];
    end

    // Next state and strobes; strobes are suppressed by hold and restart.
    always_comb begin
        stateNext  = state;
        seed_ready = 1'b0;
        loadData   = 1'b0;
        writeData  = 1'b0;
        writeout   = 1'b0;
        accept     = 1'b0;
        case (state)
            LD_IDLE: begin
                seed_ready = ~restart;
                accept     = seed_valid & ~restart;
                if (seed_valid) stateNext = LD_SHIFT;
            end
            LD_SHIFT: begin
                loadData  = ~hold & ~restart;
                writeData = ~hold & ~restart;
                if (!hold && lastCell) stateNext = LD_SETTLE;
            end
            LD_SETTLE: begin
                if (!hold) stateNext = LD_COMMIT;
            end
            LD_COMMIT: begin
                writeout = ~hold & ~restart;
                if (!hold) stateNext = LD_IDLE;
            end
            default: stateNext = LD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clka) begin
        if (restart) state <= LD_IDLE;
        else         state <= stateNext;
    end

    // Seed capture, serial shift, and the per-seed status registers.
    always_ff @(posedge clka) begin
        if (restart) begin
            shiftReg   <= '0;
            idx        <= '0;
            load_done  <= 1'b0;
            seed_pop   <= '0;
            empty_seed <= 1'b0;
        end else begin
            load_done <= (state == LD_COMMIT) & ~hold;
            if (accept) begin
                shiftReg   <= seedOrdered;
                idx        <= '0;
                seed_pop   <= popNow;
                empty_seed <= (popNow == 5'd0);
            end else if (state == LD_SHIFT && !hold) begin
                shiftReg <= shiftReg >> 1;
                // idx parks at the last cell so count stays meaningful afterwards
                if (!lastCell) idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seed_loader.sv
// Self-checking bench for seed_loader: directed timing cases plus a random
// phase, both checked every cycle against a step-counting reference model.
module tb_seed_loader;

    logic        clka = 1'b0;
    logic        restart = 1'b1;
    logic        seed_valid = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] seed_data = 16'h0;

    // LSB-first instance
    logic       seed_ready, DataIn, loadData, writeData, readData, writeout, busy, load_done, empty_seed;
    logic [8:0] count;
    logic [4:0] seed_pop;
    // MSB-first instance
    logic       readyB, dataInB, loadB, writeB, readB, woB, busyB, doneB, emptyB;
    logic [8:0] countB;
    logic [4:0] popB;

    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    seed_loader #(.CELLS(16), .CNT_W(9), .LSB_FIRST(1'b1)) uDut (
        .clka(clka), .restart(restart), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(seed_ready), .hold(hold), .DataIn(DataIn), .count(count),
        .loadData(loadData), .writeData(writeData), .readData(readData), .writeout(writeout),
        .busy(busy), .load_done(load_done), .seed_pop(seed_pop), .empty_seed(empty_seed)
    );

    seed_loader #(.CELLS(16), .CNT_W(9), .LSB_FIRST(1'b0)) uMsb (
        .clka(clka), .restart(restart), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(readyB), .hold(hold), .DataIn(dataInB), .count(countB),
        .loadData(loadB), .writeData(writeB), .readData(readB), .writeout(woB),
        .busy(busyB), .load_done(doneB), .seed_pop(popB), .empty_seed(emptyB)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A load is 18 non-hold steps: 0..15 present cells, 16 settles, 17 commits.
    bit          armed    = 1'b0;
    bit          refBusy  = 1'b0;
    bit          refFresh = 1'b1;
    bit          refDone  = 1'b0;
    bit          refEmpty = 1'b0;
    int          refStep  = 0;
    int          refIdx   = 0;
    int          refPop   = 0;
    logic [15:0] refSeed  = 16'h0;

    always @(negedge clka) begin
        if (armed) begin
            logic rdy, stb, wo;
            rdy = !refBusy && !restart;
            stb = refBusy && refStep < 16 && !hold && !restart;
            wo  = refBusy && refStep == 17 && !hold && !restart;
            chk("seed_ready", seed_ready, rdy);   chk("seed_ready_b", readyB, rdy);
            chk("loadData", loadData, stb);       chk("loadData_b", loadB, stb);
            chk("writeData", writeData, stb);     chk("writeData_b", writeB, stb);
            chk("writeout", writeout, wo);        chk("writeout_b", woB, wo);
            chk("readData", readData, 0);         chk("readData_b", readB, 0);
            chk("busy", busy, refBusy);           chk("busy_b", busyB, refBusy);
            chk("load_done", load_done, refDone); chk("load_done_b", doneB, refDone);
            chk("seed_pop", seed_pop, refPop);    chk("seed_pop_b", popB, refPop);
            chk("empty_seed", empty_seed, refEmpty); chk("empty_seed_b", emptyB, refEmpty);
            chk("count", count, refIdx);          chk("count_b", countB, refIdx);
            if (refBusy && refStep < 16) begin
                chk("DataIn", DataIn, refSeed[refStep]);
                chk("DataIn_b", dataInB, refSeed[15-refStep]);
            end else if (refFresh) begin
                chk("DataIn_rst", DataIn, 0);
                chk("DataIn_rst_b", dataInB, 0);
            end
        end
        // advance model with the inputs the next edge will sample
        if (restart) begin
            refBusy = 0; refStep = 0; refIdx = 0; refPop = 0;
            refEmpty = 0; refDone = 0; refFresh = 1; armed = 1;
        end else begin
            refDone = refBusy && refStep == 17 && !hold;
            if (!refBusy) begin
                if (seed_valid) begin
                    refBusy = 1; refStep = 0; refIdx = 0; refSeed = seed_data;
                    refPop = $countones(seed_data); refEmpty = (refPop == 0); refFresh = 0;
                end
            end else if (!hold) begin
                if (refStep == 17) refBusy = 0;
                else               refStep++;
                if (refBusy && refStep <= 15) refIdx = refStep;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic nextCycle();
        @(posedge clka);
        #1;
    endtask

    // Offer one seed in the current cycle (cycle 0), run until load_done.
    task automatic runLoad(input logic [15:0] sd, input int hs, input int he,
                           output int woC, output int dnC, output int nStb,
                           output logic [15:0] gL, output logic [15:0] gM,
                           output int cnt6, output logic ld6);
        seed_valid = 1'b1; seed_data = sd; hold = 1'b0;
        nextCycle();
        seed_valid = 1'b0; seed_data = 16'($urandom);
        woC = -1; dnC = -1; nStb = 0; gL = 16'h0; gM = 16'h0; cnt6 = -1; ld6 = 1'bx;
        for (int c = 1; c <= 40 && dnC < 0; c++) begin
            hold = (c >= hs && c <= he);
            @(negedge clka);
            if (loadData) begin
                nStb++;
                gL[count[3:0]] = DataIn;
                gM[countB[3:0]] = dataInB;
            end
            if (writeout && woC < 0) woC = c;
            if (load_done) dnC = c;
            if (c == 6) begin cnt6 = int'(count); ld6 = loadData; end
            nextCycle();
        end
        hold = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int woC, dnC, nStb, cnt6;
        logic [15:0] gL, gM;
        logic ld6;
        bit woSeen;
        int found;

        // reset held two cycles
        restart = 1'b1;
        nextCycle();
        @(negedge clka);
        chk("rst_busy", busy, 0);       chk("rst_count", count, 0);
        chk("rst_pop", seed_pop, 0);    chk("rst_datain", DataIn, 0);
        chk("rst_done", load_done, 0);  chk("rst_empty", empty_seed, 0);
        chk("rst_ready", seed_ready, 0); chk("rst_wo", writeout, 0);
        nextCycle();
        restart = 1'b0;
        @(negedge clka);
        chk("ready_after_rst", seed_ready, 1);
        nextCycle();

        // basic load, A5A5
        runLoad(16'hA5A5, 0, -1, woC, dnC, nStb, gL, gM, cnt6, ld6);
        chk("basic_cells", gL, 16'hA5A5);  chk("basic_cells_b", gM, 16'hA5A5);
        chk("basic_nstb", nStb, 16);       chk("basic_wo_cyc", woC, 18);
        chk("basic_done_cyc", dnC, 19);    chk("basic_pop", seed_pop, 8);
        chk("basic_empty", empty_seed, 0);

        // stall in cycles 5..7
        runLoad(16'h3C96, 5, 7, woC, dnC, nStb, gL, gM, cnt6, ld6);
        chk("stall_cells", gL, 16'h3C96);  chk("stall_nstb", nStb, 16);
        chk("stall_cnt_frozen", cnt6, 4);  chk("stall_strobe_low", ld6, 0);
        chk("stall_wo_cyc", woC, 21);      chk("stall_done_cyc", dnC, 22);
        chk("stall_pop", seed_pop, 8);

        // reset in cycle 10 of a load
        seed_valid = 1'b1; seed_data = 16'h1234;
        nextCycle();
        seed_valid = 1'b0;
        woSeen = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clka); if (writeout) woSeen = 1;
            nextCycle();
        end
        restart = 1'b1;
        @(negedge clka);
        chk("midrst_wo", writeout, 0); chk("midrst_load", loadData, 0);
        nextCycle();
        restart = 1'b0;
        @(negedge clka);
        chk("midrst_busy_next", busy, 0); chk("midrst_ready_next", seed_ready, 1);
        nextCycle();
        for (int c = 12; c <= 30; c++) begin
            @(negedge clka); if (writeout) woSeen = 1;
            nextCycle();
        end
        chk("midrst_no_wo", woSeen, 0);

        // all-zero seed afterwards
        runLoad(16'h0000, 0, -1, woC, dnC, nStb, gL, gM, cnt6, ld6);
        chk("zero_cells", gL, 16'h0000);  chk("zero_nstb", nStb, 16);
        chk("zero_wo_cyc", woC, 18);      chk("zero_done_cyc", dnC, 19);
        chk("zero_pop", seed_pop, 0);     chk("zero_empty", empty_seed, 1);

        // back-to-back: FFFF then 0001 with seed_valid held high
        seed_valid = 1'b1; seed_data = 16'hFFFF;
        nextCycle();
        seed_data = 16'h0001;
        for (int c = 1; c <= 18; c++) nextCycle();
        @(negedge clka);
        chk("b2b_done_19", load_done, 1); chk("b2b_ready_19", seed_ready, 1);
        chk("b2b_pop_full", seed_pop, 16);
        nextCycle();
        seed_valid = 1'b0;
        @(negedge clka);
        chk("b2b_load_20", loadData, 1); chk("b2b_count_20", count, 0);
        chk("b2b_cell0", DataIn, 1);     chk("b2b_cell0_b", dataInB, 0);
        chk("b2b_pop_one", seed_pop, 1);
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            nextCycle();
            @(negedge clka);
            if (load_done) found = 1;
        end
        chk("b2b_second_done", found, 1);
        nextCycle();

        // MSB-first ordering, seed 8000
        runLoad(16'h8000, 0, -1, woC, dnC, nStb, gL, gM, cnt6, ld6);
        chk("msb_cells_b", gM, 16'h0001); chk("msb_cells_lsb", gL, 16'h8000);
        chk("msb_pop", popB, 1);          chk("msb_done_cyc", dnC, 19);

        // random phase
        for (int i = 0; i < 1500; i++) begin
            restart    = ($urandom_range(0, 59) == 0);
            seed_valid = ($urandom_range(0, 2) != 0);
            hold       = ($urandom_range(0, 4) == 0);
            seed_data  = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
            nextCycle();
        end
        restart = 1'b0; seed_valid = 1'b0; hold = 1'b0;
        nextCycle();
        @(negedge clka);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
